// File: rtl/mdu_pkg.sv
// +-----------------------------------------------------------------------------
// | mdu_pkg : MDU opcode encodings, default latencies and op-class helpers.
// | Optional MADD/MADDU/MSUB/MSUBU group enabled by macro MDU_MADD_EN.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [5:0] {
    OP_NOP   = 6'd0,
    OP_MULT  = 6'd1,
    OP_MULTU = 6'd2,
    OP_DIV   = 6'd3,
    OP_DIVU  = 6'd4,
    OP_MTHI  = 6'd5,
    OP_MTLO  = 6'd6,
    OP_MFHI  = 6'd7,
    OP_MFLO  = 6'd8,
    OP_MADD  = 6'd9,
    OP_MADDU = 6'd10,
    OP_MSUB  = 6'd11,
    OP_MSUBU = 6'd12
  } mdu_op_e;

  // Ops that run for MULT_CYCLES.
  function automatic logic is_mul_op(input logic [5:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
    return op inside {OP_MULT, OP_MULTU};
`endif
  endfunction

  function automatic logic is_div_op(input logic [5:0] op);
    return op inside {OP_DIV, OP_DIVU};
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
`ifdef MDU_MADD_EN
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
`else
    return op inside {OP_MULT, OP_DIV};
`endif
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_calc.sv
// +-----------------------------------------------------------------------------
// | mdu_calc : combinational 64-bit {HI,LO} result from latched op/operands.
// | Accumulate ops present only when MDU_MADD_EN is defined.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mdu_calc
  import mdu_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        wr_en
);

  logic        sgn;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        neg_q;
  logic        neg_r;

  always_comb begin
    sgn   = is_signed_op(op);
    ext_a = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    ext_b = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    // Low 64 bits of the extended product are correct for both signednesses.
    prod  = ext_a * ext_b;

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    mag_a = (sgn && a[31]) ? -a : a;
    mag_b = (sgn && b[31]) ? -b : b;
    q_mag = (b == 32'd0) ? 32'd0 : mag_a / mag_b;
    r_mag = (b == 32'd0) ? 32'd0 : mag_a % mag_b;
    neg_q = sgn && (a[31] ^ b[31]);
    neg_r = sgn && a[31];

    result = {hi, lo};
    wr_en  = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        result = prod;
        wr_en  = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        result = {(neg_r ? -r_mag : r_mag), (neg_q ? -q_mag : q_mag)};
        wr_en  = (b != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU: begin
        result = {hi, lo} + prod;
        wr_en  = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        result = {hi, lo} - prod;
        wr_en  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// +-----------------------------------------------------------------------------
// | mdu_unit : multi-cycle multiply/divide unit with HI/LO registers.
// | Define MDU_MADD_EN to add MADD/MADDU/MSUB/MSUBU. Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [5:0]  MDUop,
  input  logic        Req,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic [31:0] MDUout,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] MULT_LAT = MULT_CYCLES[3:0];
  localparam logic [3:0] DIV_LAT  = DIV_CYCLES[3:0];

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        busy_q, busy_d;
  logic        accept;
  logic [63:0] calc_res;
  logic        calc_wr;

  mdu_calc u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (calc_res),
    .wr_en  (calc_wr)
  );

  always_comb begin
    accept = start && !Req && !busy_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;

    if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
      // Commit on the final busy edge; Req no longer matters here.
      if (cnt_q == 4'd1 && calc_wr) begin
        {hi_d, lo_d} = calc_res;
      end
    end else if (accept) begin
      if (is_mul_op(MDUop) || is_div_op(MDUop)) begin
        cnt_d = is_div_op(MDUop) ? DIV_LAT : MULT_LAT;
        op_d  = MDUop;
        a_d   = A;
        b_d   = B;
      end else if (MDUop == OP_MTHI) begin
        hi_d = A;
      end else if (MDUop == OP_MTLO) begin
        lo_d = A;
      end
    end

    busy_d = (cnt_d != 4'd0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      cnt_q  <= 4'd0;
      op_q   <= 6'd0;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      busy_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      cnt_q  <= cnt_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    MDUout = 32'd0;
    if (MDUop == OP_MFHI) MDUout = hi_q;
    else if (MDUop == OP_MFLO) MDUout = lo_q;
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// +-----------------------------------------------------------------------------
// | tb_mdu_unit : directed self-checking bench for mdu_unit.
// | Define MDU_MADD_EN to also exercise the accumulate group. Revision: 1.0
// +-----------------------------------------------------------------------------
`default_nettype none

module tb_mdu_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  MDUop = 6'd0;
  logic        Req = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        Busy;
  logic [31:0] MDUout;
  logic [31:0] HI;
  logic [31:0] LO;

  int errors = 0;
  int checks = 0;
  int cyc;

  mdu_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .MDUop  (MDUop),
    .Req    (Req),
    .A      (A),
    .B      (B),
    .Busy   (Busy),
    .MDUout (MDUout),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-edge issue, used for single-cycle ops and rejected starts.
  task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req);
    start = 1'b1; MDUop = op; A = a; B = b; Req = req;
    tick();
    start = 1'b0; MDUop = OP_NOP; Req = 1'b0;
  endtask

  // Issue a multi-cycle op and count busy cycles; optionally raise Req or a
  // second start at a given busy cycle number (0 = never).
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int req_at, input int restart_at, output int cycles);
    issue(op, a, b, 1'b0);
    cycles = 0;
    while (Busy && cycles < 40) begin
      cycles++;
      if (cycles == req_at) Req = 1'b1;
      if (cycles == restart_at) begin
        start = 1'b1; MDUop = OP_MULTU; A = 32'd5; B = 32'd5;
      end
      tick();
      if (cycles == restart_at) begin
        start = 1'b0; MDUop = OP_NOP;
      end
    end
    Req = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    MDUop = OP_MFHI;
    #10;
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", Busy, 0);
    check("rst_mduout", MDUout, 0);
    reset = 1'b1;
    MDUop = OP_NOP;
    tick();

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0, cyc);
    check("mult_cycles", cyc, 5);
    check("mult_hi", HI, 64'hFFFF_FFFF);
    check("mult_lo", LO, 64'hFFFF_FFFA);

    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0, 0, cyc);
    check("multu_hi", HI, 2);
    check("multu_lo", LO, 64'hFFFF_FFFA);

    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, cyc);
    check("div_cycles", cyc, 10);
    check("div_lo", LO, 64'hFFFF_FFFD);
    check("div_hi", HI, 64'hFFFF_FFFF);

    run_op(OP_DIVU, 32'd100, 32'd0, 0, 0, cyc);
    check("divu0_cycles", cyc, 10);
    check("divu0_hi", HI, 64'hFFFF_FFFF);
    check("divu0_lo", LO, 64'hFFFF_FFFD);

    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, cyc);
    check("divovf_lo", LO, 64'h8000_0000);
    check("divovf_hi", HI, 0);

    issue(OP_MTHI, 32'h1234, 32'd0, 1'b0);
    check("mthi_busy", Busy, 0);
    MDUop = OP_MFHI;
    #1 check("mfhi_out", MDUout, 64'h1234);
    issue(OP_MTLO, 32'h55, 32'd0, 1'b0);
    check("mtlo_busy", Busy, 0);
    MDUop = OP_MFLO;
    #1 check("mflo_out", MDUout, 64'h55);
    MDUop = OP_MULT;
    #1 check("other_out", MDUout, 0);
    MDUop = OP_NOP;

    issue(OP_MULT, 32'd7, 32'd9, 1'b1);
    check("req_mult_busy", Busy, 0);
    check("req_mult_hi", HI, 64'h1234);
    check("req_mult_lo", LO, 64'h55);
    issue(OP_MTHI, 32'hDEAD, 32'd0, 1'b1);
    check("req_mthi_hi", HI, 64'h1234);

    issue(6'h3F, 32'hBEEF, 32'd1, 1'b0);
    check("undef_busy", Busy, 0);
    check("undef_hi", HI, 64'h1234);
    check("undef_lo", LO, 64'h55);
`ifndef MDU_MADD_EN
    issue(OP_MADD, 32'd2, 32'd3, 1'b0);
    check("madd_off_busy", Busy, 0);
    check("madd_off_lo", LO, 64'h55);
`endif

    run_op(OP_MULT, 32'd7, 32'd6, 2, 0, cyc);
    check("reqmid_cycles", cyc, 5);
    check("reqmid_lo", LO, 42);
    check("reqmid_hi", HI, 0);

    run_op(OP_MULT, 32'd2, 32'd3, 0, 2, cyc);
    check("restart_cycles", cyc, 5);
    check("restart_lo", LO, 6);
    tick();
    check("restart_idle", Busy, 0);
    check("restart_lo2", LO, 6);

    issue(OP_MULT, 32'd9, 32'd9, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rstmid_hi", HI, 0);
    check("rstmid_lo", LO, 0);
    check("rstmid_busy", Busy, 0);
    #2 reset = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("rstmid_lo_late", LO, 0);
    check("rstmid_busy_late", Busy, 0);

    run_op(OP_MULT, 32'd3, 32'd4, 0, 0, cyc);
    check("resume_cycles", cyc, 5);
    check("resume_lo", LO, 12);

`ifdef MDU_MADD_EN
    issue(OP_MTHI, 32'd0, 32'd0, 1'b0);
    issue(OP_MTLO, 32'd1, 32'd0, 1'b0);
    run_op(OP_MADD, 32'd2, 32'd3, 0, 0, cyc);
    check("madd_cycles", cyc, 5);
    check("madd_lo", LO, 7);
    check("madd_hi", HI, 0);
    run_op(OP_MSUB, 32'd1, 32'd8, 0, 0, cyc);
    check("msub_lo", LO, 64'hFFFF_FFFF);
    check("msub_hi", HI, 64'hFFFF_FFFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving multiply latency in cycles, legal range 1..15.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving divide latency in cycles, legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1 bit: EX-stage MDU instruction valid this cycle.
REQ-006 SHALL have port MDUop, input, 6 bits: operation code; encodings are listed in mdu_pkg.
REQ-007 SHALL have port Req, input, 1 bit: exception/interrupt request; cancels the EX-stage instruction.
REQ-008 SHALL have port A, input, 32 bits: forwarded rs operand.
REQ-009 SHALL have port B, input, 32 bits: forwarded rt operand.
REQ-010 SHALL have port Busy, output, 1 bit: a multi-cycle operation is in progress.
REQ-011 SHALL have port MDUout, output, 32 bits: read data for MFHI/MFLO.
REQ-012 SHALL have port HI, output, 32 bits, and port LO, output, 32 bits: architectural registers, for the bench.

Function
REQ-013 SHALL support these ops: MULT and MULTU (signed/unsigned 64-bit product; HI = upper word, LO = lower word).
REQ-014 SHALL support DIV and DIVU (signed/unsigned; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend).
REQ-015 SHALL support MTHI and MTLO, which write A into HI/LO at the issuing edge, 0-cycle latency, Busy stays low.
REQ-016 SHALL support MFHI and MFLO: MDUout is combinational HI or LO selected by MDUop; MDUout = 0 for any other op.
REQ-017 SHALL accept an operation at an edge only when start=1, Req=0 and Busy=0.
REQ-018 SHALL, on accepting MULT/MULTU/DIV/DIVU: latch the operands, load the counter with the op's latency, and assert Busy from the next cycle.
REQ-019 SHALL decrement the counter each edge while it is nonzero; Busy = (counter != 0), registered.
REQ-020 SHALL write HI/LO on the edge where the counter goes 1->0, so Busy is high for exactly N cycles and HI/LO are valid in the first cycle Busy is low.
REQ-021 SHALL ignore start while Busy=1; HI/LO and the counter are unaffected (upstream stalls on start|Busy).
REQ-022 SHALL leave HI and LO unchanged when the divisor is 0 for DIV/DIVU; Busy still runs the full DIV_CYCLES.
REQ-023 SHALL ignore start when start and Req coincide, including for MTHI/MTLO; no state changes.
REQ-024 SHALL let an operation already in progress finish when Req=1 (it is already committed).
REQ-025 SHALL treat DIV of 0x80000000 by 0xFFFFFFFF as giving LO = 0x80000000, HI = 0.
REQ-026 SHALL treat undefined MDUop values with start=1 as no-ops.

Reset
REQ-027 SHALL, while reset=0, asynchronously clear HI, LO, the counter, the latched operands and Busy to 0; MDUout therefore reads 0.
REQ-028 SHALL abort an in-flight operation if reset is asserted mid-operation; no HI/LO write follows, and normal acceptance resumes at the first edge after reset deasserts.

Configuration
REQ-029 SHALL, when macro MDU_MADD_EN is defined, add MADD, MADDU, MSUB and MSUBU: {HI,LO} +/- the signed/unsigned product, using MULT_CYCLES latency and the same Busy/Req rules.
REQ-030 SHALL, without MDU_MADD_EN, treat those opcodes as no-ops per REQ-026 and generate no accumulate logic.

Structure
REQ-031 SHALL place the MDUop encodings (including the MADD group) and the default latency constants in shared package mdu_pkg, which the decoder also uses.
REQ-032 SHALL contain one combinational sub-module, mdu_calc, that computes the 64-bit {HI,LO} result from the latched op, latched operands and current HI/LO; mdu_unit holds only the counter, registers and control.

Verification
REQ-033 SHALL cover MULT: A=0xFFFFFFFE, B=3 -> Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=2, LO=0xFFFFFFFA.
REQ-034 SHALL cover DIV: A=-7, B=2 -> Busy high 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIVU with B=0 -> HI/LO unchanged.
REQ-035 SHALL cover MTHI A=0x1234 then MFHI in the next cycle -> MDUout=0x1234, Busy never high.
REQ-036 SHALL cover start+MULT together with Req=1 -> Busy stays 0, HI/LO unchanged; and Req raised at Busy cycle 2 -> result still written at cycle 5.
REQ-037 SHALL cover a second start during Busy -> ignored; and reset=0 at Busy cycle 3 -> HI=LO=0, Busy=0 immediately, no later write.
REQ-038 SHALL cover, with MDU_MADD_EN, HI=0, LO=1 then MADD A=2, B=3 -> LO=7 after 5 cycles.
